// File: rtl/naes_pkg.sv
// Shared types and bus addresses for the CPU-side OAM DMA engine.
package naes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIG = 16'h4014;
  localparam logic [15:0] PPU_OAMDATA  = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: on a CPU write to the trigger address, halts the CPU and
// copies one 256-byte page onto the PPU OAM data port via the shared databus.
module oam_dma
  import naes_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAM_DMA_TRIG,
  parameter logic [15:0] OAM_ADDR  = PPU_OAMDATA,
  parameter int unsigned XFER_LEN  = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_CE,
  input  logic [15:0] ADDR,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DO,
  input  logic [7:0]  BUS_IN,
  output logic        DMA,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_WR,
  output logic [7:0]  DMA_DO,
  output logic        CPU_HALT
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  state;
  dma_state_t  state_nxt;
  logic        parity;
  logic        parity_nxt;
  logic [7:0]  idx;
  logic [7:0]  idx_nxt;
  logic [7:0]  idx_inc;
  logic [7:0]  page;
  logic [7:0]  page_nxt;
  logic        dma_nxt;
  logic [15:0] dma_addr_nxt;
  logic        dma_wr_nxt;
  logic [7:0]  dma_do_nxt;
  logic        cpu_halt_nxt;
  logic        trigger;

  // DMA=0 keeps the engine's own bus writes from ever looking like a trigger.
  assign trigger = !CPU_WR && (ADDR == TRIG_ADDR) && !DMA;
  // 8-bit increment: the page byte is never carried into.
  assign idx_inc = idx + 8'h01;

  // Next-state and next-output logic; everything holds between CPU_CE pulses.
  always_comb begin
    state_nxt    = state;
    parity_nxt   = parity;
    idx_nxt      = idx;
    page_nxt     = page;
    dma_nxt      = DMA;
    dma_addr_nxt = DMA_ADDR;
    dma_wr_nxt   = DMA_WR;
    dma_do_nxt   = DMA_DO;
    cpu_halt_nxt = CPU_HALT;
    if (CPU_CE) begin
      parity_nxt = ~parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            page_nxt     = CPU_DO;
            idx_nxt      = 8'h00;
            state_nxt    = HALT;
            cpu_halt_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        HALT: begin
          // An extra cycle is inserted so every READ lands on an even CE.
          if (!parity) begin
            state_nxt = ALIGN;
          end else begin
            state_nxt    = READ;
            dma_nxt      = 1'b1;
            dma_addr_nxt = {page, idx};
            dma_wr_nxt   = 1'b1;
          end
        end
        ALIGN: begin
          state_nxt    = READ;
          dma_nxt      = 1'b1;
          dma_addr_nxt = {page, idx};
          dma_wr_nxt   = 1'b1;
        end
        READ: begin
          state_nxt    = WRITE;
          dma_do_nxt   = BUS_IN;
          dma_addr_nxt = OAM_ADDR;
          dma_wr_nxt   = 1'b0;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state_nxt    = IDLE;
            idx_nxt      = 8'h00;
            dma_nxt      = 1'b0;
            dma_addr_nxt = 16'h0000;
            dma_wr_nxt   = 1'b1;
            cpu_halt_nxt = 1'b0;
          end else begin
            state_nxt    = READ;
            idx_nxt      = idx_inc;
            dma_addr_nxt = {page, idx_inc};
            dma_wr_nxt   = 1'b1;
          end
        end
        default: begin
          state_nxt    = IDLE;
          dma_nxt      = 1'b0;
          dma_addr_nxt = 16'h0000;
          dma_wr_nxt   = 1'b1;
          cpu_halt_nxt = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      parity   <= 1'b0;
      idx      <= 8'h00;
      page     <= 8'h00;
      DMA      <= 1'b0;
      DMA_ADDR <= 16'h0000;
      DMA_WR   <= 1'b1;
      DMA_DO   <= 8'h00;
      CPU_HALT <= 1'b0;
    end else begin
      state    <= state_nxt;
      parity   <= parity_nxt;
      idx      <= idx_nxt;
      page     <= page_nxt;
      DMA      <= dma_nxt;
      DMA_ADDR <= dma_addr_nxt;
      DMA_WR   <= dma_wr_nxt;
      DMA_DO   <= dma_do_nxt;
      CPU_HALT <= cpu_halt_nxt;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a memory model answers DMA reads and a
// scoreboard of expected bus operations is matched against every DMA CE.
module tb_oam_dma;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
    logic        par;
  } bus_op_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CPU_CE;
  logic [15:0] ADDR;
  logic        CPU_WR;
  logic [7:0]  CPU_DO;
  logic [7:0]  BUS_IN;
  logic        DMA;
  logic [15:0] DMA_ADDR;
  logic        DMA_WR;
  logic [7:0]  DMA_DO;
  logic        CPU_HALT;

  logic [7:0]  mem [0:65535];
  bus_op_t     exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          halt_ces = 0;
  int          ops_seen = 0;
  logic        par = 1'b0;

  oam_dma dut (
    .Clk(Clk), .Reset(Reset), .CPU_CE(CPU_CE), .ADDR(ADDR), .CPU_WR(CPU_WR),
    .CPU_DO(CPU_DO), .BUS_IN(BUS_IN), .DMA(DMA), .DMA_ADDR(DMA_ADDR),
    .DMA_WR(DMA_WR), .DMA_DO(DMA_DO), .CPU_HALT(CPU_HALT)
  );

  always #5 Clk = ~Clk;

  assign BUS_IN = (DMA && DMA_WR) ? mem[DMA_ADDR] : 8'hFF;

  // Scoreboard: every DMA CE must match the next expected bus operation.
  always @(negedge Clk) begin
    bus_op_t e;
    if (Reset === 1'b1) begin
      par = 1'b0;
    end else if (CPU_CE === 1'b1) begin
      if (CPU_HALT === 1'b1) halt_ces++;
      if (DMA === 1'b1) begin
        ops_seen++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_op: got addr=%h wr=%b do=%h, required no DMA op", DMA_ADDR, DMA_WR, DMA_DO);
        end else begin
          e = exp_q.pop_front();
          if (DMA_ADDR !== e.addr || DMA_WR !== e.wr || (!e.wr && DMA_DO !== e.data) || par !== e.par) begin
            fails++;
            $display("FAIL bus_op: got addr=%h wr=%b do=%h par=%b, required addr=%h wr=%b do=%h par=%b",
                     DMA_ADDR, DMA_WR, DMA_DO, par, e.addr, e.wr, e.data, e.par);
          end
        end
      end
      par = ~par;
    end
  end

  task automatic ce(input logic wr, input logic [15:0] a, input logic [7:0] d, input int gap);
    CPU_CE = 1'b1; CPU_WR = wr; ADDR = a; CPU_DO = d;
    @(posedge Clk); #1;
    CPU_CE = 1'b0; CPU_WR = 1'b1; ADDR = 16'h0000; CPU_DO = 8'h00;
    repeat (gap) begin @(posedge Clk); #1; end
  endtask

  task automatic start_xfer(input logic want_par, input logic [7:0] pg);
    bus_op_t e;
    int n = 0;
    while (par !== want_par && n < 4) begin ce(1'b1, 16'h0000, 8'h00, 0); n++; end
    halt_ces = 0;
    for (int i = 0; i < 256; i++) begin
      e.addr = {pg, 8'(i)}; e.wr = 1'b1; e.data = 8'h00; e.par = 1'b0;
      exp_q.push_back(e);
      e.addr = 16'h2004; e.wr = 1'b0; e.data = mem[{pg, 8'(i)}]; e.par = 1'b1;
      exp_q.push_back(e);
    end
    ce(1'b0, 16'h4014, pg, 0);
  endtask

  task automatic finish_xfer(input int gap, input int exp_halt, input string name);
    int n = 0;
    while (CPU_HALT === 1'b1 && n < 700) begin ce(1'b1, 16'h0000, 8'h00, gap); n++; end
    tests++;
    if (CPU_HALT !== 1'b0) begin fails++; $display("FAIL %s_timeout: CPU_HALT=%b after %0d CEs, required 0", name, CPU_HALT, n); end
    tests++;
    if (halt_ces != exp_halt) begin fails++; $display("FAIL %s_halt_count: got %0d, required %0d", name, halt_ces, exp_halt); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s_ops_left: got %0d, required 0", name, exp_q.size()); end
    tests++;
    if (DMA !== 1'b0 || DMA_WR !== 1'b1 || DMA_ADDR !== 16'h0000) begin
      fails++; $display("FAIL %s_end_state: got dma=%b wr=%b addr=%h, required 0 1 0000", name, DMA, DMA_WR, DMA_ADDR);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1; CPU_CE = 1'b0; CPU_WR = 1'b1; ADDR = 16'h0000; CPU_DO = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    if (DMA !== 1'b0 || DMA_ADDR !== 16'h0000 || DMA_WR !== 1'b1 || DMA_DO !== 8'h00 || CPU_HALT !== 1'b0) begin
      fails++; $display("FAIL reset_state: got dma=%b addr=%h wr=%b do=%h halt=%b, required 0 0000 1 00 0", DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT);
    end
    Reset = 1'b0;
  endtask

  task automatic test_even_trigger();
    start_xfer(1'b0, 8'h02);
    finish_xfer(0, 513, "even");
  endtask

  task automatic test_odd_trigger();
    start_xfer(1'b1, 8'h02);
    finish_xfer(0, 514, "odd");
  endtask

  task automatic test_rom_page();
    start_xfer(1'b0, 8'h80);
    finish_xfer(0, 513, "rom");
  endtask

  task automatic test_mid_reset();
    int base = ops_seen;
    int n = 0;
    int h;
    start_xfer(1'b0, 8'h02);
    while (ops_seen - base < 128 && n < 400) begin ce(1'b1, 16'h0000, 8'h00, 0); n++; end
    tests++;
    if (DMA !== 1'b1 || DMA_WR !== 1'b1 || DMA_ADDR !== 16'h0240) begin
      fails++; $display("FAIL mid_read: got dma=%b wr=%b addr=%h, required 1 1 0240", DMA, DMA_WR, DMA_ADDR);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tests++;
    if (DMA !== 1'b0 || CPU_HALT !== 1'b0 || DMA_WR !== 1'b1 || DMA_ADDR !== 16'h0000 || DMA_DO !== 8'h00) begin
      fails++; $display("FAIL mid_reset_state: got dma=%b halt=%b wr=%b addr=%h do=%h, required 0 0 1 0000 00", DMA, CPU_HALT, DMA_WR, DMA_ADDR, DMA_DO);
    end
    exp_q.delete();
    h = halt_ces;
    base = ops_seen;
    repeat (20) ce(1'b1, 16'h0000, 8'h00, 0);
    tests++;
    if (ops_seen != base || halt_ces != h) begin
      fails++; $display("FAIL post_reset_quiet: got ops=%0d halts=%0d, required 0 0", ops_seen - base, halt_ces - h);
    end
    start_xfer(1'b0, 8'h03);
    finish_xfer(0, 513, "restart");
  endtask

  task automatic test_ce_gap();
    logic [26:0] snap;
    int n = 0;
    start_xfer(1'b0, 8'h02);
    while (CPU_HALT === 1'b1 && n < 700) begin
      ce(1'b1, 16'h0000, 8'h00, 0);
      snap = {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT};
      repeat (7) begin
        @(posedge Clk); #1;
        tests++;
        if ({DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT} !== snap) begin
          fails++; $display("FAIL gap_stable: got %h, required %h", {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT}, snap);
        end
      end
      n++;
    end
    finish_xfer(0, 513, "gap");
  endtask

  task automatic test_negative_triggers();
    halt_ces = 0;
    ce(1'b1, 16'h4014, 8'h05, 0);
    ce(1'b0, 16'h4015, 8'h05, 0);
    repeat (6) ce(1'b1, 16'h0000, 8'h00, 0);
    tests++;
    if (CPU_HALT !== 1'b0 || halt_ces != 0) begin
      fails++; $display("FAIL no_trigger: got halt=%b halt_ces=%0d, required 0 0", CPU_HALT, halt_ces);
    end
    start_xfer(1'b0, 8'h02);
    repeat (10) ce(1'b1, 16'h0000, 8'h00, 0);
    ce(1'b0, 16'h4014, 8'h77, 0);
    finish_xfer(0, 513, "busy");
    repeat (6) ce(1'b1, 16'h0000, 8'h00, 0);
    tests++;
    if (CPU_HALT !== 1'b0) begin
      fails++; $display("FAIL busy_no_restart: got halt=%b, required 0", CPU_HALT);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 13) ^ 8'(i >> 8);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'h0300 + i] = ~8'(i);
      mem[16'h8000 + i] = 8'(i * 7 + 3);
      mem[16'h8100 + i] = 8'hEE;
    end
    test_reset();
    test_even_trigger();
    test_odd_trigger();
    test_rom_page();
    test_mid_reset();
    test_ce_gap();
    test_negative_triggers();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side initiator for the databus DMA port.
- Detects a CPU write to $4014, halts the CPU, then drives DMA/DMA_ADDR through the system databus to copy one 256-byte page to PPU OAM through $2004.
- Sequence per byte: read from {page,idx}, write to $2004.
- Sits beside the CPU core; the top level muxes its address, data and write strobe onto the databus while DMA=1.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
- OAM_ADDR, 16'h2004, destination address for every DMA write
- XFER_LEN, 256, bytes per transfer; idx is 8 bits, so XFER_LEN must be 256

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- CPU_CE  input  1  one-Clk pulse per CPU cycle; all state advances only when CPU_CE=1
- ADDR  input  16  CPU address
- CPU_WR  input  1  CPU read/write, 1=read, 0=write
- CPU_DO  input  8  CPU write data; page number on trigger
- BUS_IN  input  8  databus BUS_OUT, the read data during DMA reads
- DMA  output  1  databus uses DMA_ADDR when 1
- DMA_ADDR  output  16  DMA bus address
- DMA_WR  output  1  DMA read/write, same polarity as CPU_WR
- DMA_DO  output  8  byte driven on the bus during DMA writes
- CPU_HALT  output  1  CPU stalls while 1

Behaviour:
- All outputs are registered. Reset values: DMA=0, DMA_ADDR=16'h0000, DMA_WR=1, DMA_DO=8'h00, CPU_HALT=0.
- Reset also clears: state=IDLE, PARITY=0, idx=0, page=0.
- PARITY toggles on every CPU_CE, including while IDLE. A CE with PARITY=0 is an "even" CPU cycle.
- Trigger condition, evaluated only in IDLE: CPU_CE=1, CPU_WR=0, ADDR==TRIG_ADDR, DMA=0.
  - On trigger: latch page=CPU_DO, idx=0, go to HALT.
  - Reads of TRIG_ADDR do not trigger.
  - Writes to other addresses do not trigger.
- States, each advancing on CPU_CE:
  - IDLE: CPU_HALT=0, DMA=0.
  - HALT: CPU_HALT=1, DMA=0. Dummy cycle. Next state is ALIGN if PARITY=0 at this CE, else READ.
  - ALIGN: CPU_HALT=1, DMA=0. One cycle, then READ.
  - READ: DMA=1, DMA_ADDR={page,idx}, DMA_WR=1. At CE, latch DMA_DO=BUS_IN, then go to WRITE.
  - WRITE: DMA=1, DMA_ADDR=OAM_ADDR, DMA_WR=0, DMA_DO holds the latched byte. At CE:
    - if idx==8'hFF, go to IDLE; idx wraps to 0;
    - else idx=idx+1, go to READ.
- Parity rules:
  - READ CEs always fall on PARITY=0.
  - WRITE CEs always fall on PARITY=1.
- Cycle counts:
  - Trigger on an even CE: CPU_HALT high for exactly 513 CEs.
  - Trigger on an odd CE: 514 CEs.
- Address arithmetic is an 8-bit page/idx concatenation with no carry; idx never touches page.
- Leaving WRITE to IDLE: in the same clock, CPU_HALT=0, DMA=0, DMA_WR=1, DMA_ADDR=16'h0000.
- Between CEs: state and outputs hold; no bus activity changes.
- Triggers are ignored while not IDLE. The DMA's own $2004 writes can never retrigger.
- Page range: any page value is legal, including 8'h20–8'h3F and 8'h40. These read whatever the databus returns, with no special-casing. Pages 8'h80–8'hFF read PRG ROM.
- Reset mid-transfer: takes effect on the next Clk regardless of CPU_CE. All outputs return to reset values and no further $2004 write is issued.

Decomposition:
- Package naes_pkg holds:
  - enum dma_state_t {IDLE, HALT, ALIGN, READ, WRITE};
  - localparams for the OAM_DMA_TRIG ($4014) and PPU_OAMDATA ($2004) addresses.
- Single module; no sub-module. The parity toggle and idx counter are a few lines each.

Test Plan:
- Even trigger, page 8'h02: preload RAM $0200+i=i^8'h5A, write 8'h02 to $4014 on a PARITY=0 CE → CPU_HALT high 513 CEs; 256 READ/WRITE pairs $0200..$02FF then $2004; write n carries n^8'h5A.
- Odd trigger, page 8'h02: same stimulus on a PARITY=1 CE → 514 CEs; first READ one CE later and on PARITY=0.
- Page 8'h80: PRG ROM pattern → DMA_ADDR sweeps $8000..$80FF, no carry into $8100; last write carries ROM[$80FF].
- Reset at idx=8'h40, mid-READ → next Clk shows DMA=0, CPU_HALT=0, DMA_WR=1; no further $2004 writes. A new trigger with page 8'h03 restarts at $0300.
- CPU_CE held low 7 Clks between pulses throughout a transfer → outputs stable between CEs; sequence and 513 count unchanged.
- Negative triggers: read $4014 (CPU_WR=1), write $4015, and write $4014 while busy → no new transfer; the busy-case transfer still ends at idx 8'hFF.
